uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 143 ++++++++++++++
 tb/tb_uart_tx_mmio.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: a DATA register feeding a small TX FIFO, a STATUS register,
// and an 8N1 serializer whose line output comes straight from a flop.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ready_q, ovf_q;
  logic [31:0]     rdata_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      mem [FIFO_DEPTH];

  logic access, wr_data, rd_stat, full, empty, busy, push, pop, baud_wrap;
  logic [31:0] status;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  always_comb begin
    access    = sel && !ready_q;
    wr_data   = access && we && (addr == 4'h0);
    rd_stat   = access && !we && (addr == 4'h4);
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    busy      = (state_q != IDLE);
    status    = {28'b0, ovf_q, busy, empty, full};
    // The full test deliberately ignores a pop on the same edge.
    push      = wr_data && !full;
    pop       = (state_q == IDLE) && !empty;
    baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= access;
      rdata_q <= rd_stat ? status : 32'h0;
      if (wr_data && full) ovf_q <= 1'b1;
      else if (rd_stat)    ovf_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata[7:0];
    shift_q <= shift_d;
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus accesses scored against a timeline model of FIFO and frames,
// with a serial-line monitor checking every tx cycle against the expected frame schedule.
module tb_uart_tx_mmio;
  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        tx;

  uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: each accepted byte with its push edge and the edge its frame starts.
  logic [7:0] m_byte [128];
  int m_push [128];
  int m_pop  [128];
  int n_acc = 0;
  int last_pop = -1000;
  bit m_ovf = 1'b0;

  int mon_k = 0;
  int mon_pos = 0;
  bit mon_in = 1'b0;

  logic [31:0] b_rd, b_rd_pre, b_exp;
  logic        b_rdy_pre, b_rdy_hi, b_rdy_after;

  function automatic int occ(input int t);
    int n = 0;
    for (int i = 0; i < n_acc; i++)
      if (m_push[i] < t && m_pop[i] >= t) n++;
    return n;
  endfunction

  function automatic bit busy_at(input int t);
    bit b = 1'b0;
    for (int i = 0; i < n_acc; i++)
      if (m_pop[i] < t && t <= m_pop[i] + FRAME) b = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    n_acc = 0;
    last_pop = -1000;
    m_ovf = 1'b0;
  endtask

  task automatic bus(input bit w, input logic [3:0] a, input logic [31:0] d);
    int t, p, o;
    @(negedge clk);
    b_rdy_pre = ready;
    b_rd_pre = rdata;
    t = cyc + 1;
    sel = 1'b1; we = w; addr = a; wdata = d;
    b_exp = 32'h0;
    if (w && a == 4'h0) begin
      if (occ(t) < D) begin
        p = (t + 1 > last_pop + FRAME + 1) ? t + 1 : last_pop + FRAME + 1;
        m_byte[n_acc] = d[7:0];
        m_push[n_acc] = t;
        m_pop[n_acc] = p;
        last_pop = p;
        n_acc++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (!w && a == 4'h4) begin
      o = occ(t);
      b_exp = {28'b0, m_ovf, busy_at(t), o == 0, o == D};
      m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    b_rdy_hi = ready;
    b_rd = rdata;
    sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
    @(posedge clk);
    #1;
    b_rdy_after = ready;
  endtask

  task automatic wait_idle();
    int end_t;
    end_t = (n_acc > 0) ? m_pop[n_acc-1] + FRAME + 2 : cyc + 2;
    for (int i = 0; i < 4000 && cyc < end_t; i++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic monitor();
    int idx;
    logic expb;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_in = 1'b0;
        mon_k = 0;
      end else begin
        if (!mon_in && tx === 1'b0) begin
          checks++;
          if (mon_k >= n_acc) begin
            errors++;
            $display("FAIL unexpected_start cyc=%0d tx=%b required 1 (no byte queued)", cyc, tx);
          end else if (cyc != m_pop[mon_k]) begin
            errors++;
            $display("FAIL start_time frame%0d start edge=%0d required %0d", mon_k, cyc, m_pop[mon_k]);
          end
          mon_in = 1'b1;
          mon_pos = 0;
        end else if (!mon_in && mon_k < n_acc && cyc >= m_pop[mon_k]) begin
          checks++;
          errors++;
          $display("FAIL missing_frame frame%0d tx=%b required 0 at edge %0d", mon_k, tx, m_pop[mon_k]);
          mon_k++;
        end
        if (mon_in) begin
          idx = mon_pos / C;
          expb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_byte[mon_k & 127][idx-1];
          checks++;
          if (tx !== expb) begin
            errors++;
            $display("FAIL frame_bit frame%0d bit%0d cyc=%0d tx=%b required %b", mon_k, idx, cyc, tx, expb);
          end
          mon_pos++;
          if (mon_pos == FRAME) begin
            mon_in = 1'b0;
            mon_k++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs tx=%b ready=%b rdata=%h required 1/0/0", tx, ready, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== 32'h2 || b_rd !== b_exp) begin
      errors++;
      $display("FAIL reset_status rdata=%h required 00000002", b_rd);
    end
    checks++;
    if (b_rdy_pre !== 1'b0 || b_rd_pre !== 32'h0 || b_rdy_hi !== 1'b1 || b_rdy_after !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_pulse pre=%b/%h hi=%b after=%b required 0/0 1 0",
               b_rdy_pre, b_rd_pre, b_rdy_hi, b_rdy_after);
    end
  endtask

  task automatic test_pattern_55();
    logic [39:0] seen, want;
    logic [9:0] bits;
    bus(1'b1, 4'h0, 32'hFFFF_FF55);
    bits = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      seen[j] = tx;
      want[j] = bits[j / C];
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL pattern_55 tx=%h required %h", seen, want);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL pattern_55_idle tx=%b required 1", tx);
    end
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== 32'h2 || b_rd !== b_exp) begin
      errors++;
      $display("FAIL pattern_55_status rdata=%h required 00000002", b_rd);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bus(1'b1, 4'h0, 32'h0000_00A3);
    bus(1'b1, 4'h0, 32'h0000_000F);
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== b_exp || b_rd !== 32'h4) begin
      errors++;
      $display("FAIL b2b_status rdata=%h required %h", b_rd, b_exp);
    end
    wait_idle();
    checks++;
    if (mon_k !== n_acc) begin
      errors++;
      $display("FAIL b2b_frames seen=%0d required %0d", mon_k, n_acc);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) bus(1'b1, 4'h0, 32'h10 + i);
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== 32'hD || b_rd !== b_exp) begin
      errors++;
      $display("FAIL ovf_status1 rdata=%h required 0000000d", b_rd);
    end
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== 32'h5 || b_rd !== b_exp) begin
      errors++;
      $display("FAIL ovf_status2 rdata=%h required 00000005", b_rd);
    end
    wait_idle();
    checks++;
    if (mon_k !== n_acc || n_acc < 5) begin
      errors++;
      $display("FAIL ovf_frames seen=%0d required %0d", mon_k, n_acc);
    end
  endtask

  task automatic test_unmapped();
    bus(1'b0, 4'hC, 32'h0);
    checks++;
    if (b_rd !== 32'h0 || b_rdy_hi !== 1'b1 || b_rdy_after !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_read rdata=%h ready=%b required 0 1", b_rd, b_rdy_hi);
    end
    bus(1'b1, 4'h4, 32'hFFFF_FFFF);
    checks++;
    if (b_rdy_hi !== 1'b1) begin
      errors++;
      $display("FAIL status_write_ready ready=%b required 1", b_rdy_hi);
    end
    bus(1'b0, 4'h0, 32'h0);
    checks++;
    if (b_rd !== 32'h0) begin
      errors++;
      $display("FAIL data_read rdata=%h required 0", b_rd);
    end
    bus(1'b1, 4'h8, 32'h0000_00AA);
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== 32'h2 || b_rd !== b_exp) begin
      errors++;
      $display("FAIL unmapped_status rdata=%h required 00000002", b_rd);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        bus(1'b1, 4'h0, $urandom);
      end else if (r < 9) begin
        bus(1'b0, 4'h4, 32'h0);
        checks++;
        if (b_rd !== b_exp || b_rdy_hi !== 1'b1) begin
          errors++;
          $display("FAIL rand_status op%0d rdata=%h ready=%b required %h 1", n, b_rd, b_rdy_hi, b_exp);
        end
      end else begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
      end
    end
    wait_idle();
    checks++;
    if (mon_k !== n_acc) begin
      errors++;
      $display("FAIL rand_frames seen=%0d required %0d", mon_k, n_acc);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit stuck;
    bus(1'b1, 4'h0, 32'h3C);
    bus(1'b1, 4'h0, 32'h81);
    bus(1'b1, 4'h0, 32'h7E);
    bus(1'b1, 4'h0, 32'h99);
    for (int i = 0; i < 200 && cyc < m_pop[0] + 3 * C + 1; i++) @(posedge clk);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_async tx=%b ready=%b rdata=%h required 1/0/0", tx, ready, rdata);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 4'h4, 32'h0);
    checks++;
    if (b_rd !== 32'h2 || b_rd !== b_exp) begin
      errors++;
      $display("FAIL abort_status rdata=%h required 00000002", b_rd);
    end
    stuck = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) stuck = 1'b1;
    end
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle tx left idle=%b required 0", stuck);
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        test_reset();
        test_pattern_55();
        test_back_to_back();
        test_overflow();
        test_unmapped();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d required finish before %0d", cyc, 50000);
    $fatal(1, "timeout");
  end
endmodule
